uart_feedback_receiver: RTL and testbench



---
 rtl/uart_feedback_receiver_pkg.sv | 19 +
 rtl/uart_feedback_receiver_rx_core.sv | 115 +++++++++++
 rtl/uart_feedback_receiver.sv | 106 ++++++++++
 tb/tb_uart_feedback_receiver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_feedback_receiver_pkg.sv
// Shared definitions for the UART feedback receive path: channel codes,
// receiver FSM state encoding and the machine-id range check.
package uart_feedback_receiver_pkg;

   localparam logic [1:0] CH_TARGET = 2'b11;
   localparam logic [1:0] CH_STATUS = 2'b01;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   // Id 0 is reserved, so the legal window is 1..maxId inclusive.
   function automatic logic idInRange(input logic [4:0] id, input logic [4:0] maxId);
      return (id != 5'd0) && (id <= maxId);
   endfunction

endpackage

// File: rtl/uart_feedback_receiver_rx_core.sv
// 8N1 UART deserialiser: two-flop synchroniser, centre-sampling FSM and bit timing.
// Strobes are combinational from the state register; the top registers them.
module uart_rx_core
   import uart_feedback_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       frame_err_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

   logic             rxMeta_q;
   logic             rxSync_q;
   logic [2:0]       state_q,  state_d;
   logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
   logic [2:0]       bitIdx_q, bitIdx_d;
   logic [7:0]       shift_q,  shift_d;

   // Synchroniser resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      clkCnt_d    = clkCnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      valid_o     = 1'b0;
      frame_err_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxSync_q) begin
               state_d  = ST_START;
               clkCnt_d = '0;
               bitIdx_d = '0;
            end
         end
         ST_START: begin
            if (clkCnt_q == HALF_LAST) begin
               clkCnt_d = '0;
               bitIdx_d = '0;
               state_d  = rxSync_q ? ST_IDLE : ST_DATA;
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (clkCnt_q == BIT_LAST) begin
               clkCnt_d = '0;
               shift_d  = {rxSync_q, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 1'b1;
               if (bitIdx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (clkCnt_q == BIT_LAST) begin
               clkCnt_d = '0;
               if (rxSync_q) begin
                  valid_o = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_o = 1'b1;
                  state_d     = ST_WAIT_HIGH;
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (rxSync_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         clkCnt_q <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         clkCnt_q <= clkCnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
      end
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/uart_feedback_receiver.sv
// UART feedback receiver: deserialises host bytes and decodes the channel field
// into target-acknowledge and status holding registers with one-cycle strobes.
module uart_feedback_receiver
   import uart_feedback_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 10417,
   parameter int MAX_MACHINE_ID = 20
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err,
   output logic [4:0] target_ack_id,
   output logic       target_ack_valid,
   output logic       id_err,
   output logic [5:0] status,
   output logic       status_valid
);

   localparam logic [4:0] MAX_ID = 5'(MAX_MACHINE_ID);

   logic [7:0] coreByte;
   logic       coreValid;
   logic       coreFrameErr;

   logic [7:0] rxByte_q,      rxByte_d;
   logic       rxValid_q,     rxValid_d;
   logic       frameErr_q,    frameErr_d;
   logic [4:0] ackId_q,       ackId_d;
   logic       ackValid_q,    ackValid_d;
   logic       idErr_q,       idErr_d;
   logic [5:0] status_q,      status_d;
   logic       statusValid_q, statusValid_d;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx),
      .byte_o      (coreByte),
      .valid_o     (coreValid),
      .frame_err_o (coreFrameErr)
   );

   // Holding registers keep their value between bytes; only the strobes self-clear.
   always_comb begin
      rxByte_d      = rxByte_q;
      ackId_d       = ackId_q;
      status_d      = status_q;
      rxValid_d     = 1'b0;
      frameErr_d    = coreFrameErr;
      ackValid_d    = 1'b0;
      idErr_d       = 1'b0;
      statusValid_d = 1'b0;
      if (coreValid) begin
         rxByte_d  = coreByte;
         rxValid_d = 1'b1;
         if (coreByte[1:0] == CH_TARGET) begin
            if (idInRange(coreByte[6:2], MAX_ID)) begin
               ackId_d    = coreByte[6:2];
               ackValid_d = 1'b1;
            end else begin
               idErr_d = 1'b1;
            end
         end else if (coreByte[1:0] == CH_STATUS) begin
            status_d      = coreByte[7:2];
            statusValid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxByte_q      <= '0;
         rxValid_q     <= 1'b0;
         frameErr_q    <= 1'b0;
         ackId_q       <= '0;
         ackValid_q    <= 1'b0;
         idErr_q       <= 1'b0;
         status_q      <= '0;
         statusValid_q <= 1'b0;
      end else begin
         rxByte_q      <= rxByte_d;
         rxValid_q     <= rxValid_d;
         frameErr_q    <= frameErr_d;
         ackId_q       <= ackId_d;
         ackValid_q    <= ackValid_d;
         idErr_q       <= idErr_d;
         status_q      <= status_d;
         statusValid_q <= statusValid_d;
      end
   end

   assign rx_byte          = rxByte_q;
   assign rx_valid         = rxValid_q;
   assign frame_err        = frameErr_q;
   assign target_ack_id    = ackId_q;
   assign target_ack_valid = ackValid_q;
   assign id_err           = idErr_q;
   assign status           = status_q;
   assign status_valid     = statusValid_q;

endmodule

// File: tb/tb_uart_feedback_receiver.sv
// Directed testbench for uart_feedback_receiver with a fast bit period;
// strobes are tallied on the falling edge and checked as before/after deltas.
module tb_uart_feedback_receiver;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;
   logic [4:0] target_ack_id;
   logic       target_ack_valid;
   logic       id_err;
   logic [5:0] status;
   logic       status_valid;

   int compareCount = 0;
   int failCount    = 0;

   int rxValidCnt     = 0;
   int frameErrCnt    = 0;
   int ackValidCnt    = 0;
   int idErrCnt       = 0;
   int statusValidCnt = 0;

   int baseRxValid, baseFrameErr, baseAckValid, baseIdErr, baseStatusValid;

   uart_feedback_receiver #(
      .CLKS_PER_BIT   (CPB),
      .MAX_MACHINE_ID (20)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rx               (rx),
      .rx_byte          (rx_byte),
      .rx_valid         (rx_valid),
      .frame_err        (frame_err),
      .target_ack_id    (target_ack_id),
      .target_ack_valid (target_ack_valid),
      .id_err           (id_err),
      .status           (status),
      .status_valid     (status_valid)
   );

   always #5 clk = ~clk;

   // Strobe tally on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rx_valid)         rxValidCnt     <= rxValidCnt + 1;
      if (frame_err)        frameErrCnt    <= frameErrCnt + 1;
      if (target_ack_valid) ackValidCnt    <= ackValidCnt + 1;
      if (id_err)           idErrCnt       <= idErrCnt + 1;
      if (status_valid)     statusValidCnt <= statusValidCnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic driveBit(input logic b);
      @(posedge clk);
      rx = b;
      waitCycles(CPB - 1);
   endtask

   // Start bit, 8 data bits LSB first, then the given stop-bit level.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) begin
         driveBit(data[i]);
      end
      driveBit(stopBit);
   endtask

   task automatic snapshot();
      @(negedge clk);
      baseRxValid     = rxValidCnt;
      baseFrameErr    = frameErrCnt;
      baseAckValid    = ackValidCnt;
      baseIdErr       = idErrCnt;
      baseStatusValid = statusValidCnt;
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      waitCycles(5);
      @(posedge clk);
      rst = 1'b0;

      waitCycles(500);
      @(negedge clk);
      checkOutput("idle_rx_byte",    32'(rx_byte),       32'h00);
      checkOutput("idle_ack_id",     32'(target_ack_id), 32'h00);
      checkOutput("idle_status",     32'(status),        32'h00);
      checkOutput("idle_pulses",     32'(rxValidCnt + frameErrCnt + ackValidCnt + idErrCnt + statusValidCnt), 32'd0);

      // Abandon a frame by reset partway through the data bits.
      snapshot();
      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b1);
      driveBit(1'b1);
      @(posedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      waitCycles(3);
      @(posedge clk);
      rst = 1'b0;
      waitCycles(300);
      @(negedge clk);
      checkOutput("rst_mid_pulses",  32'(rxValidCnt + frameErrCnt + ackValidCnt + idErrCnt + statusValidCnt - baseRxValid - baseFrameErr - baseAckValid - baseIdErr - baseStatusValid), 32'd0);

      // 0x0F: channel 11, id 3.
      snapshot();
      applyStimulus(8'h0F, 1'b1);
      waitCycles(30);
      @(negedge clk);
      checkOutput("ack3_rx_byte",    32'(rx_byte),       32'h0F);
      checkOutput("ack3_rx_valid",   32'(rxValidCnt - baseRxValid),   32'd1);
      checkOutput("ack3_ack_id",     32'(target_ack_id), 32'd3);
      checkOutput("ack3_ack_valid",  32'(ackValidCnt - baseAckValid), 32'd1);

      // 0x57: channel 11, id 21 is out of range.
      snapshot();
      applyStimulus(8'h57, 1'b1);
      waitCycles(30);
      @(negedge clk);
      checkOutput("id21_id_err",     32'(idErrCnt - baseIdErr),       32'd1);
      checkOutput("id21_ack_id",     32'(target_ack_id), 32'd3);
      checkOutput("id21_ack_valid",  32'(ackValidCnt - baseAckValid), 32'd0);
      checkOutput("id21_rx_byte",    32'(rx_byte),       32'h57);

      // 0xA5 then 0x03 with no idle gap.
      snapshot();
      applyStimulus(8'hA5, 1'b1);
      applyStimulus(8'h03, 1'b1);
      waitCycles(30);
      @(negedge clk);
      checkOutput("b2b_rx_valid",    32'(rxValidCnt - baseRxValid),       32'd2);
      checkOutput("b2b_status",      32'(status),        32'h29);
      checkOutput("b2b_status_vld",  32'(statusValidCnt - baseStatusValid), 32'd1);
      checkOutput("b2b_id_err",      32'(idErrCnt - baseIdErr),           32'd1);
      checkOutput("b2b_rx_byte",     32'(rx_byte),       32'h03);
      checkOutput("b2b_ack_id",      32'(target_ack_id), 32'd3);

      // 0x0F with a low stop bit, then the line held low before release.
      snapshot();
      applyStimulus(8'h0F, 1'b0);
      waitCycles(100);
      @(posedge clk);
      rx = 1'b1;
      waitCycles(50);
      @(negedge clk);
      checkOutput("ferr_frame_err",  32'(frameErrCnt - baseFrameErr),  32'd1);
      checkOutput("ferr_rx_valid",   32'(rxValidCnt - baseRxValid),    32'd0);
      checkOutput("ferr_ack_valid",  32'(ackValidCnt - baseAckValid),  32'd0);
      checkOutput("ferr_rx_byte",    32'(rx_byte),       32'h03);
      checkOutput("ferr_ack_id",     32'(target_ack_id), 32'd3);

      snapshot();
      applyStimulus(8'h13, 1'b1);
      waitCycles(30);
      @(negedge clk);
      checkOutput("after_ferr_ack_id",  32'(target_ack_id), 32'd4);
      checkOutput("after_ferr_ack_vld", 32'(ackValidCnt - baseAckValid), 32'd1);

      // Short low glitch must not start a frame.
      snapshot();
      @(posedge clk);
      rx = 1'b0;
      waitCycles(4);
      rx = 1'b1;
      waitCycles(60);
      @(negedge clk);
      checkOutput("glitch_pulses",   32'(rxValidCnt + frameErrCnt + ackValidCnt + idErrCnt + statusValidCnt - baseRxValid - baseFrameErr - baseAckValid - baseIdErr - baseStatusValid), 32'd0);
      checkOutput("glitch_rx_byte",  32'(rx_byte),       32'h13);

      applyStimulus(8'h0B, 1'b1);
      waitCycles(30);
      @(negedge clk);
      checkOutput("after_glitch_ack_id", 32'(target_ack_id), 32'd2);
      checkOutput("after_glitch_rx_byte", 32'(rx_byte),      32'h0B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
